tile_plotter: RTL and testbench

TILE_PLOTTER -- requirements
Module: tile_plotter

---
 rtl/tile_plotter_if.sv | 29 ++
 rtl/tile_plotter.sv | 152 +++++++++++++++
 tb/tb_tile_plotter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_plotter_if.sv
// Request, ROM and VGA pixel signals of the tile plotter.
// slave is the plotter side; master is the side that drives requests and ROM data.
interface tile_plotter_if;
    logic        plot;
    logic        ld_sprite;
    logic [2:0]  sprite_sel;
    logic [3:0]  tile_addr;
    logic [3:0]  tile_id;
    logic [13:0] rom_addr;
    logic [2:0]  rom_data;
    logic [17:0] spr_addr;
    logic [2:0]  spr_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        done;
    logic        busy;

    modport master (
        output plot, ld_sprite, sprite_sel, tile_addr, tile_id, rom_data, spr_data,
        input  rom_addr, spr_addr, x, y, colour, writeEn, done, busy
    );

    modport slave (
        input  plot, ld_sprite, sprite_sel, tile_addr, tile_id, rom_data, spr_data,
        output rom_addr, spr_addr, x, y, colour, writeEn, done, busy
    );
endinterface

// File: rtl/tile_plotter.sv
// Draws one TILE x TILE board tile or a 160x120 sprite from synchronous ROMs to a VGA writer.
// Define TILE_BORDER_EN to paint the outer ring of every non-blank tile in colour 3'b111.
module tile_plotter #(
    parameter int unsigned X_OFF = 20,
    parameter int unsigned Y_OFF = 0,
    parameter int unsigned TILE  = 30
) (
    input logic           clock,
    input logic           resetN,
    tile_plotter_if.slave bus
);
`ifdef TILE_BORDER_EN
    localparam bit BorderEn = 1'b1;
`else
    localparam bit BorderEn = 1'b0;
`endif
    localparam logic [7:0] TileLast = 8'(TILE - 1);
    localparam logic [7:0] SprLastX = 8'd159;
    localparam logic [6:0] SprLastY = 7'd119;

    typedef enum logic [2:0] {StIdle, StTileDraw, StSpriteDraw, StFlush, StDone} state_t;

    state_t     state;
    logic [7:0] cntX;
    logic [6:0] cntY;
    logic [1:0] tileCol;
    logic [1:0] tileRow;
    logic [3:0] tileId;
    logic [2:0] spriteSel;
    logic       isSprite;
    logic       armed;
    logic       pipeVld;
    logic       pipeEdge;
    logic [7:0] pipeX;
    logic [6:0] pipeY;

    logic       tileEnd;
    logic       spriteEnd;
    logic       edgePix;
    logic [7:0] tileX;
    logic [6:0] tileY;

    always_comb begin
        tileEnd   = (cntX == TileLast) && (cntY == TileLast[6:0]);
        spriteEnd = (cntX == SprLastX) && (cntY == SprLastY);
        edgePix   = (cntX == 8'd0) || (cntX == TileLast) ||
                    (cntY == 7'd0) || (cntY == TileLast[6:0]);
        tileX     = 8'(X_OFF + 32'(tileCol) * TILE + 32'(cntX));
        tileY     = 7'(Y_OFF + 32'(tileRow) * TILE + 32'(cntY));
    end

    assign bus.rom_addr = {tileId, cntY[4:0], cntX[4:0]};
    assign bus.spr_addr = {spriteSel, cntY, cntX};

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state       <= StIdle;
            cntX        <= '0;
            cntY        <= '0;
            tileCol     <= '0;
            tileRow     <= '0;
            tileId      <= '0;
            spriteSel   <= '0;
            isSprite    <= 1'b0;
            armed       <= 1'b1;
            pipeVld     <= 1'b0;
            pipeEdge    <= 1'b0;
            pipeX       <= '0;
            pipeY       <= '0;
            bus.writeEn <= 1'b0;
            bus.x       <= '0;
            bus.y       <= '0;
            bus.colour  <= '0;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            // Output stage: the pixel addressed last cycle meets its ROM data now.
            bus.writeEn <= pipeVld;
            bus.x       <= pipeX;
            bus.y       <= pipeY;
            if (isSprite)                  bus.colour <= bus.spr_data;
            else if (tileId == 4'd15)      bus.colour <= 3'b000;
            else if (BorderEn && pipeEdge) bus.colour <= 3'b111;
            else                           bus.colour <= bus.rom_data;
            pipeVld  <= 1'b0;
            bus.done <= 1'b0;
            if (!bus.ld_sprite) armed <= 1'b1;

            case (state)
                StIdle: begin
                    cntX <= '0;
                    cntY <= '0;
                    if (bus.plot) begin
                        tileCol  <= bus.tile_addr[1:0];
                        tileRow  <= bus.tile_addr[3:2];
                        tileId   <= bus.tile_id;
                        isSprite <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= StTileDraw;
                    end else if (bus.ld_sprite && armed) begin
                        spriteSel <= bus.sprite_sel;
                        isSprite  <= 1'b1;
                        armed     <= 1'b0;
                        bus.busy  <= 1'b1;
                        state     <= StSpriteDraw;
                    end
                end
                StTileDraw: begin
                    pipeVld  <= 1'b1;
                    pipeX    <= tileX;
                    pipeY    <= tileY;
                    pipeEdge <= edgePix;
                    if (cntX == TileLast) begin
                        cntX <= '0;
                        if (tileEnd) begin
                            cntY  <= '0;
                            state <= StFlush;
                        end else begin
                            cntY <= cntY + 7'd1;
                        end
                    end else begin
                        cntX <= cntX + 8'd1;
                    end
                end
                StSpriteDraw: begin
                    pipeVld  <= 1'b1;
                    pipeX    <= cntX;
                    pipeY    <= cntY;
                    pipeEdge <= 1'b0;
                    if (cntX == SprLastX) begin
                        cntX <= '0;
                        if (spriteEnd) begin
                            cntY  <= '0;
                            state <= StFlush;
                        end else begin
                            cntY <= cntY + 7'd1;
                        end
                    end else begin
                        cntX <= cntX + 8'd1;
                    end
                end
                StFlush: state <= StDone;
                StDone: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_plotter.sv
// Self-checking bench for tile_plotter: randomized ROM contents against a pixel-list model.
module tb_tile_plotter;
    localparam int XOff = 20;
    localparam int YOff = 0;
    localparam int Tile = 30;

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    tile_plotter_if bus ();

    tile_plotter #(.X_OFF(XOff), .Y_OFF(YOff), .TILE(Tile)) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int compared;
    int mismatched;

    // ROM contents: constant colour or an address hash salted per test.
    int         romMode;
    logic [2:0] romConst;
    int         seed;

    function automatic logic [2:0] romFn(input int a);
        if (romMode == 0) return romConst;
        return 3'(a ^ (a >> 3) ^ (a >> 7) ^ (a >> 11) ^ seed);
    endfunction

    function automatic logic [2:0] sprFn(input int a);
        return 3'((a >> 1) ^ (a >> 5) ^ (a >> 10) ^ (a >> 15) ^ seed);
    endfunction

    always @(posedge clock) begin
        bus.rom_data <= romFn(int'(bus.rom_addr));
        bus.spr_data <= sprFn(int'(bus.spr_addr));
    end

    int         wX[$], wY[$], wC[$], wCyc[$], doneCyc[$];
    bit         watchSpr;
    logic [2:0] watchSel;
    int         sprSelBad;

    always @(negedge clock) begin
        if (bus.writeEn === 1'b1) begin
            wX.push_back(int'(bus.x));
            wY.push_back(int'(bus.y));
            wC.push_back(int'(bus.colour));
            wCyc.push_back(cyc);
        end
        if (bus.done === 1'b1) doneCyc.push_back(cyc);
        if (watchSpr && bus.busy === 1'b1 && bus.spr_addr[17:15] !== watchSel)
            sprSelBad <= sprSelBad + 1;
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_log();
        wX.delete(); wY.delete(); wC.delete(); wCyc.delete(); doneCyc.delete();
    endtask

    task automatic wait_done(input int budget, input bit scramble, input int start,
                             input int rePlotAt);
        for (int i = 0; i < budget && doneCyc.size() == 0; i++) begin
            if (scramble) begin
                bus.tile_addr  = 4'($urandom);
                bus.tile_id    = 4'($urandom);
                bus.sprite_sel = 3'($urandom);
            end
            bus.plot = (rePlotAt > 0) && (cyc + 1 == start + rePlotAt);
            tick();
        end
        bus.plot = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) tick();
        compared++;
        if ({bus.x, bus.y, bus.colour, bus.rom_addr, bus.spr_addr} !== '0) begin
            mismatched++;
            $display("FAIL reset-bus: got x=%0d y=%0d c=%0d rom=%0d spr=%0d, want all 0",
                     bus.x, bus.y, bus.colour, bus.rom_addr, bus.spr_addr);
        end
        compared++;
        if (bus.writeEn !== 1'b0) begin
            mismatched++; $display("FAIL reset-writeEn: got %b want 0", bus.writeEn);
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++; $display("FAIL reset-busy: got %b want 0", bus.busy);
        end
        compared++;
        if (bus.done !== 1'b0) begin
            mismatched++; $display("FAIL reset-done: got %b want 0", bus.done);
        end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_tile(input string name, input logic [3:0] addr, input logic [3:0] id,
                             input int mode, input logic [2:0] cst, input bit scramble,
                             input int rePlotAt);
        int eX[$], eY[$], eC[$];
        int start, bad, firstBad, gotDone, gotFirst, gotLast, gx, gy, gc;
        romMode  = mode;
        romConst = cst;
        seed     = int'($urandom_range(0, 7));
        for (int py = 0; py < Tile; py++) begin
            for (int px = 0; px < Tile; px++) begin
                int c;
                eX.push_back((XOff + int'(addr[1:0]) * Tile + px) % 256);
                eY.push_back((YOff + int'(addr[3:2]) * Tile + py) % 128);
                c = (id == 4'd15) ? 0 : int'(romFn(int'(id) * 1024 + py * 32 + px));
`ifdef TILE_BORDER_EN
                if (id != 4'd15 && (px == 0 || px == Tile - 1 || py == 0 || py == Tile - 1))
                    c = 7;
`endif
                eC.push_back(c);
            end
        end
        clear_log();
        bus.tile_addr = addr;
        bus.tile_id   = id;
        bus.plot      = 1'b1;
        start = cyc + 1;
        tick();
        bus.plot = 1'b0;
        wait_done(2 * Tile * Tile, scramble, start, rePlotAt);

        gotDone  = (doneCyc.size() > 0) ? doneCyc[0] : -1;
        gotFirst = (wCyc.size() > 0) ? wCyc[0] : -1;
        gotLast  = (wCyc.size() > 0) ? wCyc[wCyc.size() - 1] : -1;
        compared++;
        if (doneCyc.size() !== 1) begin
            mismatched++;
            $display("FAIL %s done-count: got %0d want 1", name, doneCyc.size());
        end
        compared++;
        if (gotDone !== start + Tile * Tile + 2) begin
            mismatched++;
            $display("FAIL %s done-cycle: got %0d want %0d", name, gotDone - start,
                     Tile * Tile + 2);
        end
        compared++;
        if (wX.size() !== eX.size()) begin
            mismatched++;
            $display("FAIL %s write-count: got %0d want %0d", name, wX.size(), eX.size());
        end
        compared++;
        if (gotFirst !== start + 2) begin
            mismatched++;
            $display("FAIL %s first-write-cycle: got %0d want 2", name, gotFirst - start);
        end
        compared++;
        if (gotLast !== start + Tile * Tile + 1) begin
            mismatched++;
            $display("FAIL %s last-write-cycle: got %0d want %0d", name, gotLast - start,
                     Tile * Tile + 1);
        end
        bad = 0;
        firstBad = -1;
        for (int i = 0; i < eX.size(); i++) begin
            if (i >= wX.size() || wX[i] !== eX[i] || wY[i] !== eY[i] || wC[i] !== eC[i]) begin
                bad++;
                if (firstBad < 0) firstBad = i;
            end
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            gx = (firstBad < wX.size()) ? wX[firstBad] : -1;
            gy = (firstBad < wY.size()) ? wY[firstBad] : -1;
            gc = (firstBad < wC.size()) ? wC[firstBad] : -1;
            $display("FAIL %s pixels: %0d bad; #%0d got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d",
                     name, bad, firstBad, gx, gy, gc, eX[firstBad], eY[firstBad],
                     eC[firstBad]);
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++; $display("FAIL %s idle-busy: got %b want 0", name, bus.busy);
        end
    endtask

    task automatic test_reset_mid_draw();
        int start;
        clear_log();
        romMode = 1;
        bus.tile_addr = 4'($urandom);
        bus.tile_id   = 4'($urandom_range(0, 14));
        bus.plot      = 1'b1;
        start = cyc + 1;
        tick();
        bus.plot = 1'b0;
        while (cyc + 1 < start + 400) tick();
        resetN = 1'b0;
        tick();
        compared++;
        if (bus.writeEn !== 1'b0) begin
            mismatched++; $display("FAIL abort-writeEn: got %b want 0", bus.writeEn);
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++; $display("FAIL abort-busy: got %b want 0", bus.busy);
        end
        resetN = 1'b1;
        repeat (Tile * Tile) tick();
        compared++;
        if (doneCyc.size() !== 0) begin
            mismatched++; $display("FAIL abort-done: got %0d pulses want 0", doneCyc.size());
        end
    endtask

`ifdef TILE_BORDER_EN
    task automatic test_border();
        int c20, c21;
        test_tile("border", 4'd0, 4'd0, 0, 3'b000, 1'b0, 0);
        c20 = -1;
        c21 = -1;
        for (int i = 0; i < wX.size(); i++) begin
            if (wX[i] == 20 && wY[i] == 0) c20 = wC[i];
            if (wX[i] == 21 && wY[i] == 1) c21 = wC[i];
        end
        compared++;
        if (c20 !== 7) begin
            mismatched++; $display("FAIL border-corner: got %0d want 7", c20);
        end
        compared++;
        if (c21 !== 0) begin
            mismatched++; $display("FAIL border-inner: got %0d want 0", c21);
        end
    endtask
`endif

    task automatic test_sprite(input logic [2:0] sel);
        int eC[$];
        int start, bad, gotDone;
        seed = int'($urandom_range(0, 7));
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                eC.push_back(int'(sprFn(int'(sel) * 32768 + yy * 256 + xx)));
        clear_log();
        sprSelBad      = 0;
        watchSel       = sel;
        watchSpr       = 1'b1;
        bus.sprite_sel = sel;
        bus.ld_sprite  = 1'b1;
        start = cyc + 1;
        tick();
        wait_done(19200 + 400, 1'b1, start, 0);
        gotDone = (doneCyc.size() > 0) ? doneCyc[0] : -1;
        compared++;
        if (doneCyc.size() !== 1) begin
            mismatched++; $display("FAIL sprite done-count: got %0d want 1", doneCyc.size());
        end
        compared++;
        if (gotDone !== start + 19202) begin
            mismatched++; $display("FAIL sprite done-cycle: got %0d want 19202", gotDone - start);
        end
        compared++;
        if (wX.size() !== 19200) begin
            mismatched++; $display("FAIL sprite write-count: got %0d want 19200", wX.size());
        end
        bad = 0;
        for (int i = 0; i < 19200; i++)
            if (i >= wX.size() || wX[i] !== i % 160 || wY[i] !== i / 160 || wC[i] !== eC[i])
                bad++;
        compared++;
        if (bad !== 0) begin
            mismatched++; $display("FAIL sprite pixels: got %0d bad want 0", bad);
        end
        compared++;
        if (sprSelBad !== 0) begin
            mismatched++; $display("FAIL sprite sel-msbs: got %0d off cycles want 0", sprSelBad);
        end

        // ld_sprite still held: no redraw may start.
        clear_log();
        repeat (30) tick();
        compared++;
        if (bus.busy !== 1'b0 || doneCyc.size() !== 0 || wX.size() !== 0) begin
            mismatched++;
            $display("FAIL sprite held-level: got busy=%b writes=%0d dones=%0d want 0/0/0",
                     bus.busy, wX.size(), doneCyc.size());
        end

        bus.ld_sprite = 1'b0;
        tick();
        watchSel       = ~sel;
        bus.sprite_sel = ~sel;
        bus.ld_sprite  = 1'b1;
        start = cyc + 1;
        tick();
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++; $display("FAIL sprite rearm-busy: got %b want 1", bus.busy);
        end
        sprSelBad = 0;
        wait_done(19200 + 400, 1'b0, start, 0);
        compared++;
        if (doneCyc.size() !== 1 || wX.size() !== 19200) begin
            mismatched++;
            $display("FAIL sprite redraw: got dones=%0d writes=%0d want 1/19200",
                     doneCyc.size(), wX.size());
        end
        compared++;
        if (sprSelBad !== 0) begin
            mismatched++; $display("FAIL sprite redraw-sel: got %0d off cycles want 0", sprSelBad);
        end
        bus.ld_sprite = 1'b0;
        watchSpr = 1'b0;
        tick();
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        romMode        = 0;
        romConst       = 3'b000;
        seed           = 0;
        watchSpr       = 1'b0;
        watchSel       = 3'b000;
        sprSelBad      = 0;
        bus.plot       = 1'b0;
        bus.ld_sprite  = 1'b0;
        bus.sprite_sel = 3'd0;
        bus.tile_addr  = 4'd0;
        bus.tile_id    = 4'd0;

        test_reset();
        test_tile("directed", 4'd5, 4'd3, 0, 3'b010, 1'b0, 0);
        test_tile("blank", 4'd9, 4'd15, 0, 3'b111, 1'b0, 0);
        test_tile("scramble", 4'($urandom), 4'($urandom_range(0, 14)), 1, 3'b000, 1'b1, 0);
        test_tile("replot", 4'($urandom), 4'($urandom_range(0, 14)), 1, 3'b000, 1'b0, 100);
        for (int k = 0; k < 3; k++)
            test_tile("random", 4'($urandom), 4'($urandom_range(0, 15)), 1, 3'b000, 1'b0, 0);
        test_reset_mid_draw();
        test_tile("after-abort", 4'd15, 4'($urandom_range(0, 14)), 1, 3'b000, 1'b0, 0);
`ifdef TILE_BORDER_EN
        test_border();
`endif
        test_sprite(3'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
